// File: rtl/fcn_accel_param.sv
// Bus-mapped two-layer fully-connected accelerator: parallel FC1 MACs, ReLU/shift/saturate
// requantisation, serial FC2 MAC, with start/abort/clear-done control and a level interrupt.
module fcn_accel_param #(
  parameter int IN_N  = 132,
  parameter int HID_M = 10,
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        ena,
  input  logic        wea,
  input  logic [15:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int EPW      = 32 / DW;
  localparam int LOG_EPW  = $clog2(EPW);
  localparam int X_WORDS  = IN_N / EPW;
  localparam int W1_WORDS = HID_M * X_WORDS;
  localparam int W2_WORDS = (HID_M + EPW - 1) / EPW;
  localparam int PW       = 2 * DW;
  localparam int CW       = $clog2((IN_N > HID_M) ? IN_N : HID_M);
  localparam int MW       = (HID_M > 1) ? $clog2(HID_M) : 1;
  localparam int XAW      = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
  localparam int W1AW     = (W1_WORDS > 1) ? $clog2(W1_WORDS) : 1;
  localparam int W2AW     = (W2_WORDS > 1) ? $clog2(W2_WORDS) : 1;
  localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'((1 << (DW - 1)) - 1);

  typedef enum logic [2:0] {S_IDLE, S_FC1, S_REQ, S_FC2, S_DONE} state_t;

  state_t state, nxt;

  logic [2:0]  sel;
  logic [11:0] idx;
  logic [31:0] idx_w;
  logic        unused_addr;
  logic        wr, rd, busy;
  logic        start_req, clr_req, abort_req, start_ok;
  logic        start_p0, done;
  logic [4:0]  shift;
  logic signed [ACC_W-1:0] result;
  logic [CW-1:0] cnt;
  logic        fc1_last, fc2_last, fc1_clear;
  logic [31:0] rd_data;

  logic [31:0] x_mem  [X_WORDS];
  logic [31:0] w1_mem [W1_WORDS];
  logic [31:0] w2_mem [W2_WORDS];

  logic signed [ACC_W-1:0] acc_p0 [HID_M];
  logic signed [PW-1:0]    prod_p0 [HID_M];
  logic signed [DW-1:0]    h_p1   [HID_M];
  logic signed [ACC_W-1:0] r_p2;
  logic signed [DW-1:0]    x_j, w2_m;

  function automatic logic signed [DW-1:0] lane_of(input logic [31:0] w,
                                                   input logic [LOG_EPW-1:0] l);
    return w[l*DW +: DW];
  endfunction

  function automatic logic signed [DW-1:0] relu_sat(input logic signed [ACC_W-1:0] a,
                                                    input logic [4:0] sh);
    logic signed [ACC_W-1:0] s;
    s = a >>> sh;
    if (a[ACC_W-1])    return '0;
    else if (s > H_MAX) return H_MAX[DW-1:0];
    else                return s[DW-1:0];
  endfunction

  assign sel         = addra[14:12];
  assign idx         = addra[11:0];
  assign idx_w       = {20'b0, addra[11:0]};
  assign unused_addr = addra[15];
  assign wr          = ena & wea;
  assign rd          = ena & ~wea;
  assign busy        = (state != S_IDLE);

  assign start_req = wr && (sel == 3'b101) && (idx_w == 32'd1);
  assign clr_req   = wr && (sel == 3'b101) && (idx_w == 32'd3);
  assign abort_req = wr && (sel == 3'b101) && (idx_w == 32'd4);
  assign start_ok  = start_req && !abort_req && !busy && !start_p0;

  assign fc1_last  = (cnt == CW'(IN_N - 1));
  assign fc2_last  = (cnt == CW'(HID_M - 1));
  assign fc1_clear = (state == S_IDLE) && (nxt == S_FC1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= nxt;
  end

  // FSM: next state; abort overrides every transition
  always_comb begin
    nxt = state;
    if (abort_req) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_p0) nxt = S_FC1;
        S_FC1:   if (fc1_last) nxt = S_REQ;
        S_REQ:   nxt = S_FC2;
        S_FC2:   if (fc2_last) nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state != S_IDLE);
    irq_o  = done;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      start_p0 <= 1'b0;
      done     <= 1'b0;
      shift    <= '0;
      result   <= '0;
      cnt      <= '0;
    end else begin
      start_p0 <= start_ok;
      if (!abort_req) begin
        if (start_ok || clr_req) done <= 1'b0;
        else if (state == S_DONE) done <= 1'b1;
        if (state == S_DONE) result <= r_p2;
      end
      if (wr && (sel == 3'b101) && (idx_w == 32'd2) && !busy) shift <= dina[4:0];
      if ((state == S_FC1 && !fc1_last) || (state == S_FC2 && !fc2_last)) cnt <= cnt + 1'b1;
      else cnt <= '0;
    end
  end

  // Weight/input stores: writes land only while idle and in range
  always_ff @(posedge clk) begin
    if (wr && !busy && sel == 3'b000 && idx_w < X_WORDS)  x_mem[idx[XAW-1:0]]   <= dina;
    if (wr && !busy && sel == 3'b011 && idx_w < W1_WORDS) w1_mem[idx[W1AW-1:0]] <= dina;
    if (wr && !busy && sel == 3'b100 && idx_w < W2_WORDS) w2_mem[idx[W2AW-1:0]] <= dina;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      3'b000: if (idx_w < X_WORDS)  rd_data = x_mem[idx[XAW-1:0]];
      3'b011: if (idx_w < W1_WORDS) rd_data = w1_mem[idx[W1AW-1:0]];
      3'b100: if (idx_w < W2_WORDS) rd_data = w2_mem[idx[W2AW-1:0]];
      3'b101: begin
        case (idx_w)
          32'd0:   rd_data = {30'b0, busy, done};
          32'd1:   rd_data = 32'(result);
          32'd2:   rd_data = {27'b0, shift};
          default: rd_data = '0;
        endcase
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)  douta <= '0;
    else if (rd)  douta <= rd_data;
  end

  // Stage p0: FC1, one input column per cycle across all neurons
  assign x_j = lane_of(x_mem[XAW'(cnt >> LOG_EPW)], cnt[LOG_EPW-1:0]);

  always_comb begin
    for (int n = 0; n < HID_M; n++) begin
      prod_p0[n] = PW'(lane_of(w1_mem[W1AW'(n * X_WORDS) + W1AW'(cnt >> LOG_EPW)],
                               cnt[LOG_EPW-1:0])) * PW'(x_j);
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < HID_M; n++) begin
      if (fc1_clear)            acc_p0[n] <= '0;
      else if (state == S_FC1)  acc_p0[n] <= acc_p0[n] + ACC_W'(prod_p0[n]);
    end
  end

  // Stage p1: ReLU, shift and saturate into the hidden vector
  always_ff @(posedge clk) begin
    if (state == S_REQ) begin
      for (int n = 0; n < HID_M; n++) h_p1[n] <= relu_sat(acc_p0[n], shift);
    end
  end

  // Stage p2: FC2, one hidden neuron per cycle
  assign w2_m = lane_of(w2_mem[W2AW'(cnt >> LOG_EPW)], cnt[LOG_EPW-1:0]);

  always_ff @(posedge clk) begin
    if (fc1_clear)           r_p2 <= '0;
    else if (state == S_FC2) r_p2 <= r_p2 + ACC_W'(PW'(w2_m) * PW'(h_p1[MW'(cnt)]));
  end

endmodule

// File: tb/tb_fcn_accel_param.sv
// Self-checking bench for fcn_accel_param: directed and random inference runs against a
// plain-arithmetic reference model, plus latency, abort, busy write-protect and reset cases.
module tb_fcn_accel_param;

  localparam int IN_N  = 132;
  localparam int HID_M = 10;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int EPW      = 32 / DW;
  localparam int X_WORDS  = IN_N / EPW;
  localparam int W1_WORDS = HID_M * X_WORDS;
  localparam int W2_WORDS = (HID_M + EPW - 1) / EPW;
  localparam int RUN_LAT  = IN_N + HID_M + 3;
  localparam logic [2:0] SEL_X = 3'b000, SEL_W1 = 3'b011, SEL_W2 = 3'b100, SEL_C = 3'b101;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ena = 1'b0, wea = 1'b0;
  logic [15:0] addra = '0;
  logic [31:0] dina = '0;
  logic [31:0] douta;
  logic        busy_o, irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  int x_m  [IN_N];
  int w1_m [HID_M][IN_N];
  int w2_m [HID_M];

  fcn_accel_param #(.IN_N(IN_N), .HID_M(HID_M), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .douta(douta), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] put_lane(logic [31:0] w, int l, int v);
    logic [31:0] m, vv;
    m  = (32'd1 << DW) - 32'd1;
    vv = 32'(v) & m;
    return w | (vv << (l * DW));
  endfunction

  function automatic logic [31:0] x_word(int wi);
    logic [31:0] w = '0;
    for (int l = 0; l < EPW; l++) w = put_lane(w, l, x_m[wi*EPW + l]);
    return w;
  endfunction

  function automatic logic [31:0] w1_word(int wi);
    logic [31:0] w = '0;
    for (int l = 0; l < EPW; l++) begin
      int f = wi*EPW + l;
      w = put_lane(w, l, w1_m[f / IN_N][f % IN_N]);
    end
    return w;
  endfunction

  function automatic logic [31:0] w2_word(int wi);
    logic [31:0] w = '0;
    for (int l = 0; l < EPW; l++) begin
      int f = wi*EPW + l;
      if (f < HID_M) w = put_lane(w, l, w2_m[f]);
    end
    return w;
  endfunction

  function automatic longint wrapw(longint v);
    longint m;
    m = v & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m = m - (64'sd1 <<< ACC_W);
    return m;
  endfunction

  // Reference: whole-vector dot products, then ReLU/shift/clip, then the output dot product
  function automatic longint model_result(int sh);
    longint acc, h, r;
    r = 0;
    for (int n = 0; n < HID_M; n++) begin
      acc = 0;
      for (int k = 0; k < IN_N; k++) acc += longint'(w1_m[n][k]) * longint'(x_m[k]);
      acc = wrapw(acc);
      if (acc < 0) h = 0;
      else begin
        h = acc >>> sh;
        if (h > (2**(DW-1) - 1)) h = 2**(DW-1) - 1;
      end
      r += longint'(w2_m[n]) * h;
    end
    return wrapw(r);
  endfunction

  task automatic bus_wr(input logic [2:0] sel, input int idx, input logic [31:0] d);
    logic [11:0] i12;
    i12 = idx[11:0];
    @(negedge clk);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, sel, i12}; dina = d;
    @(negedge clk);
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] sel, input int idx, output logic [31:0] d);
    logic [11:0] i12;
    i12 = idx[11:0];
    @(negedge clk);
    ena = 1'b1; wea = 1'b0; addra = {1'b0, sel, i12};
    @(negedge clk);
    d = douta;
    ena = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < X_WORDS; i++)  bus_wr(SEL_X, i, x_word(i));
    for (int i = 0; i < W1_WORDS; i++) bus_wr(SEL_W1, i, w1_word(i));
    for (int i = 0; i < W2_WORDS; i++) bus_wr(SEL_W2, i, w2_word(i));
  endtask

  task automatic fill_const(int xv, int w1v, int w2v);
    for (int k = 0; k < IN_N; k++) x_m[k] = xv;
    for (int n = 0; n < HID_M; n++) begin
      w2_m[n] = w2v;
      for (int k = 0; k < IN_N; k++) w1_m[n][k] = w1v;
    end
  endtask

  task automatic run_wait(input string name);
    bit seen = 1'b0;
    bus_wr(SEL_C, 1, 32'd0);
    for (int c = 0; c < RUN_LAT + 20 && !seen; c++) begin
      @(negedge clk);
      if (irq_o) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s_timeout: irq_o not seen within %0d cycles", name, RUN_LAT + 20);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++;
    if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_o); else n_pass++;
    n_checks++;
    if (douta !== 32'd0) $display("FAIL reset_douta: got %h expected 0", douta); else n_pass++;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    bus_rd(SEL_C, 0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_status: got %h expected 0", d); else n_pass++;
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_result: got %h expected 0", d); else n_pass++;
    bus_rd(SEL_C, 2, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_shift: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_ones();
    logic [31:0] d, exp;
    fill_const(1, 1, 1);
    load_all();
    bus_wr(SEL_C, 2, 32'd0);
    run_wait("ones");
    exp = 32'(model_result(0));
    n_checks++;
    if (irq_o !== 1'b1) $display("FAIL ones_irq: got %b expected 1", irq_o); else n_pass++;
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== exp) $display("FAIL ones_result: got %0d expected %0d", $signed(d), $signed(exp));
    else n_pass++;
    bus_wr(SEL_C, 2, 32'd2);
    run_wait("shift2");
    exp = 32'(model_result(2));
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== exp) $display("FAIL shift2_result: got %0d expected %0d", $signed(d), $signed(exp));
    else n_pass++;
    bus_rd(SEL_C, 0, d);
    n_checks++;
    if (d !== 32'h1) $display("FAIL shift2_status: got %h expected 1", d); else n_pass++;
    bus_wr(SEL_C, 2, 32'd0);
  endtask

  task automatic test_relu_neg();
    logic [31:0] d, exp;
    fill_const(1, -1, 1);
    for (int i = 0; i < W1_WORDS; i++) bus_wr(SEL_W1, i, w1_word(i));
    run_wait("relu");
    exp = 32'(model_result(0));
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== exp) $display("FAIL relu_result: got %0d expected %0d", $signed(d), $signed(exp));
    else n_pass++;
    fill_const(1, 1, -3);
    load_all();
    run_wait("negw2");
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== 32'hFFFFF11E) $display("FAIL negw2_result: got %h expected fffff11e", d);
    else n_pass++;
  endtask

  task automatic test_latency();
    int first_busy = -1, last_busy = -1, first_irq = -1;
    logic [31:0] d, exp;
    @(negedge clk);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, SEL_C, 12'd1}; dina = '0;
    for (int e = 0; e < RUN_LAT + 10; e++) begin
      @(negedge clk);
      ena = 1'b0; wea = 1'b0;
      if (busy_o) begin
        if (first_busy < 0) first_busy = e;
        last_busy = e;
      end
      if (irq_o && first_irq < 0) first_irq = e;
      if (e + 1 == 60) begin ena = 1'b1; wea = 1'b1; addra = {1'b0, SEL_C, 12'd1}; end
    end
    n_checks++;
    if (first_busy !== 1) $display("FAIL lat_first_busy: got %0d expected 1", first_busy);
    else n_pass++;
    n_checks++;
    if (last_busy !== RUN_LAT - 1)
      $display("FAIL lat_last_busy: got %0d expected %0d", last_busy, RUN_LAT - 1);
    else n_pass++;
    n_checks++;
    if (first_irq !== RUN_LAT) $display("FAIL lat_first_irq: got %0d expected %0d", first_irq, RUN_LAT);
    else n_pass++;
    exp = 32'(model_result(0));
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== exp) $display("FAIL lat_result: got %0d expected %0d", $signed(d), $signed(exp));
    else n_pass++;
  endtask

  task automatic test_abort();
    logic b49, b50;
    logic [31:0] d, old_res, w0;
    old_res = 32'(model_result(0));
    w0 = w1_word(0);
    @(negedge clk);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, SEL_C, 12'd1}; dina = '0;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      ena = 1'b0; wea = 1'b0;
      if (e == 49) b49 = busy_o;
      if (e == 50) b50 = busy_o;
      if (e + 1 == 20) begin
        ena = 1'b1; wea = 1'b1; addra = {1'b0, SEL_W1, 12'd0}; dina = ~w0;
      end
      if (e + 1 == 50) begin
        ena = 1'b1; wea = 1'b1; addra = {1'b0, SEL_C, 12'd4}; dina = '0;
      end
    end
    n_checks++;
    if (b49 !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", b49); else n_pass++;
    n_checks++;
    if (b50 !== 1'b0) $display("FAIL abort_busy_after: got %b expected 0", b50); else n_pass++;
    n_checks++;
    if (irq_o !== 1'b0) $display("FAIL abort_irq: got %b expected 0", irq_o); else n_pass++;
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== old_res) $display("FAIL abort_result: got %h expected %h", d, old_res); else n_pass++;
    bus_rd(SEL_W1, 0, d);
    n_checks++;
    if (d !== w0) $display("FAIL busy_write_dropped: got %h expected %h", d, w0); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    int sh, wi;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < IN_N; k++) x_m[k] = int'($urandom_range(255)) - 128;
      for (int n = 0; n < HID_M; n++) begin
        w2_m[n] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < IN_N; k++) w1_m[n][k] = int'($urandom_range(255)) - 128;
      end
      sh = int'($urandom_range(12));
      load_all();
      bus_wr(SEL_C, 2, 32'(sh));
      run_wait("rand");
      exp = 32'(model_result(sh));
      bus_rd(SEL_C, 1, d);
      n_checks++;
      if (d !== exp)
        $display("FAIL rand_result[%0d]: got %0d expected %0d (shift %0d)", it, $signed(d), $signed(exp), sh);
      else n_pass++;
      wi = int'($urandom_range(X_WORDS - 1));
      bus_rd(SEL_X, wi, d);
      n_checks++;
      if (d !== x_word(wi)) $display("FAIL rand_x_readback[%0d]: got %h expected %h", wi, d, x_word(wi));
      else n_pass++;
      bus_wr(SEL_C, 3, 32'd0);
      @(negedge clk);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL clear_done: got %b expected 0", irq_o); else n_pass++;
    end
    bus_rd(SEL_X, X_WORDS, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL oob_read: got %h expected 0", d); else n_pass++;
    bus_rd(3'b001, 0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL bad_sel_read: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_wr(SEL_C, 2, 32'd3);
    bus_rd(SEL_C, 2, d);
    n_checks++;
    if (d !== 32'd3) $display("FAIL shift_readback: got %h expected 3", d); else n_pass++;
    bus_wr(SEL_C, 1, 32'd0);
    repeat (IN_N + 5) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy_o); else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++;
    if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq_o); else n_pass++;
    n_checks++;
    if (douta !== 32'd0) $display("FAIL rst_douta: got %h expected 0", douta); else n_pass++;
    @(negedge clk);
    rst_ni = 1'b1;
    bus_rd(SEL_C, 2, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rst_shift: got %h expected 0", d); else n_pass++;
    bus_rd(SEL_C, 1, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rst_result: got %h expected 0", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ones();
    test_relu_neg();
    test_latency();
    test_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
